// File: rtl/game_pkg.sv
// Shared constants and types for the game renderers.
// Layer code layout is {hit, r, g, b}; hit=0 means the layer is transparent.
package game_pkg;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int PADDLE_Y = 440;
    localparam int PADDLE_W = 64;

    localparam logic [2:0] RGB_WHITE = 3'b111;
    localparam logic [2:0] RGB_BLACK = 3'b000;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        MOVING = 2'd1,
        LOST   = 2'd2
    } ball_state_e;

    typedef struct packed {
        logic hit;
        logic r;
        logic g;
        logic b;
    } layer_code_t;

endpackage

// File: rtl/draw_ball_if.sv
// Signal bundle between the ball renderer and its surroundings.
// The slave side is the ball renderer itself.
interface draw_ball_if;
    logic       frame_tick;
    logic       launch;
    logic       block_hit_x;
    logic       block_hit_y;
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] paddle_x;
    logic [3:0] o_ball;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       lost;

    modport master (
        output frame_tick, launch, block_hit_x, block_hit_y, px, py, paddle_x,
        input  o_ball, ball_x, ball_y, lost
    );

    modport slave (
        input  frame_tick, launch, block_hit_x, block_hit_y, px, py, paddle_x,
        output o_ball, ball_x, ball_y, lost
    );
endinterface

// File: rtl/rect_hit.sv
// Combinational rectangle-contains-point test; end coordinates are 11 bits
// wide so x+w and y+h never wrap.
module rect_hit (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] w,
    input  logic [9:0] h,
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic       hit
);
    logic [10:0] x_end;
    logic [10:0] y_end;

    assign x_end = {1'b0, x} + {1'b0, w};
    assign y_end = {1'b0, y} + {1'b0, h};
    assign hit   = (px >= x) && ({1'b0, px} < x_end) &&
                   (py >= y) && ({1'b0, py} < y_end);
endmodule

// File: rtl/draw_ball.sv
// Ball layer renderer: owns ball position, direction and serve/play/lost
// sequencing; position moves once per frame_tick, pixel code every clock.
module draw_ball
    import game_pkg::*;
#(
    parameter int         BALL_SIZE = 8,
    parameter int         SPEED     = 2,
    parameter logic [2:0] BALL_RGB  = RGB_WHITE
) (
    input  logic       clock,
    input  logic       reset,
    draw_ball_if.slave bus
);
    localparam logic [9:0]  SIZE10    = 10'(BALL_SIZE);
    localparam logic [9:0]  SPEED10   = 10'(SPEED);
    localparam logic [10:0] SIZE11    = 11'(BALL_SIZE);
    localparam logic [10:0] SPEED11   = 11'(SPEED);
    localparam logic [10:0] H_RES11   = 11'(H_RES);
    localparam logic [10:0] V_RES11   = 11'(V_RES);
    localparam logic [10:0] PAD_Y11   = 11'(PADDLE_Y);
    localparam logic [10:0] PAD_W11   = 11'(PADDLE_W);
    localparam logic [9:0]  SERVE_OFS = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  SERVE_Y   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0]  RIGHT_X   = 10'(H_RES - BALL_SIZE);

    ball_state_e state, state_nxt;
    logic [9:0]  ball_x, ball_y, ball_x_nxt, ball_y_nxt, serve_x;
    logic        dir_right, dir_down, dir_right_nxt, dir_down_nxt;
    logic        x_pend, y_pend, x_pend_nxt, y_pend_nxt;
    logic        hit_x, hit_y, lost, lost_nxt, pix_hit;
    logic [10:0] bx11, by11, pad11;
    layer_code_t code, code_nxt;

    assign serve_x = bus.paddle_x + SERVE_OFS;
    assign bx11    = {1'b0, ball_x};
    assign by11    = {1'b0, ball_y};
    assign pad11   = {1'b0, bus.paddle_x};
    assign hit_x   = x_pend | bus.block_hit_x;
    assign hit_y   = y_pend | bus.block_hit_y;

    rect_hit u_ball_hit (
        .x  (ball_x),
        .y  (ball_y),
        .w  (SIZE10),
        .h  (SIZE10),
        .px (bus.px),
        .py (bus.py),
        .hit(pix_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SERVE;
            ball_x    <= serve_x;
            ball_y    <= SERVE_Y;
            dir_right <= 1'b1;
            dir_down  <= 1'b0;
            x_pend    <= 1'b0;
            y_pend    <= 1'b0;
            lost      <= 1'b0;
            code      <= '0;
        end else begin
            state     <= state_nxt;
            ball_x    <= ball_x_nxt;
            ball_y    <= ball_y_nxt;
            dir_right <= dir_right_nxt;
            dir_down  <= dir_down_nxt;
            x_pend    <= x_pend_nxt;
            y_pend    <= y_pend_nxt;
            lost      <= lost_nxt;
            code      <= code_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ball_x_nxt    = ball_x;
        ball_y_nxt    = ball_y;
        dir_right_nxt = dir_right;
        dir_down_nxt  = dir_down;
        x_pend_nxt    = hit_x;
        y_pend_nxt    = hit_y;
        lost_nxt      = 1'b0;
        if (bus.frame_tick) begin
            x_pend_nxt = 1'b0;
            y_pend_nxt = 1'b0;
            unique case (state)
                SERVE: begin
                    ball_x_nxt = serve_x;
                    ball_y_nxt = SERVE_Y;
                    if (bus.launch) begin
                        state_nxt     = MOVING;
                        dir_right_nxt = 1'b1;
                        dir_down_nxt  = 1'b0;
                    end
                end
                MOVING: begin
                    // block toggles first; wall/paddle then assign direction outright
                    dir_right_nxt = dir_right ^ hit_x;
                    dir_down_nxt  = dir_down ^ hit_y;
                    if (!dir_right_nxt && ball_x < SPEED10) begin
                        ball_x_nxt    = '0;
                        dir_right_nxt = 1'b1;
                    end else if (dir_right_nxt && (bx11 + SIZE11 + SPEED11 > H_RES11)) begin
                        ball_x_nxt    = RIGHT_X;
                        dir_right_nxt = 1'b0;
                    end else begin
                        ball_x_nxt = dir_right_nxt ? ball_x + SPEED10 : ball_x - SPEED10;
                    end
                    if (!dir_down_nxt && ball_y < SPEED10) begin
                        ball_y_nxt   = '0;
                        dir_down_nxt = 1'b1;
                    end else if (dir_down_nxt && (by11 + SIZE11 <= PAD_Y11) &&
                                 (by11 + SIZE11 + SPEED11 >= PAD_Y11) &&
                                 (bx11 + SIZE11 > pad11) && (bx11 < pad11 + PAD_W11)) begin
                        ball_y_nxt   = SERVE_Y;
                        dir_down_nxt = 1'b0;
                    end else if (dir_down_nxt && (by11 + SIZE11 + SPEED11 >= V_RES11)) begin
                        state_nxt  = LOST;
                        lost_nxt   = 1'b1;
                        ball_x_nxt = ball_x;
                        ball_y_nxt = ball_y;
                    end else begin
                        ball_y_nxt = dir_down_nxt ? ball_y + SPEED10 : ball_y - SPEED10;
                    end
                end
                LOST: begin
                    state_nxt  = SERVE;
                    ball_x_nxt = serve_x;
                    ball_y_nxt = SERVE_Y;
                end
                default: state_nxt = SERVE;
            endcase
        end
    end

    always_comb begin
        code_nxt = '0;
        if (pix_hit && state != LOST) begin
            code_nxt.hit                         = 1'b1;
            {code_nxt.r, code_nxt.g, code_nxt.b} = BALL_RGB;
        end
    end

    assign bus.o_ball = code;
    assign bus.ball_x = ball_x;
    assign bus.ball_y = ball_y;
    assign bus.lost   = lost;
endmodule

// File: tb/tb_draw_ball.sv
// Bench for draw_ball: directed scenarios then random play, all compared
// cycle by cycle against a signed-velocity reference model of the ball.
module tb_draw_ball;
    import game_pkg::*;

    localparam int BS = 8;
    localparam int SP = 2;

    logic clock = 1'b0;
    logic reset;
    draw_ball_if bus();

    draw_ball dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int m_state, mx, my, vx, vy;
    bit m_hxp, m_hyp;
    int lost_seen, dut_lost;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // model states: 0 serve, 1 moving, 2 lost; vx/vy are +1/-1
    task automatic model_frame(input bit hx, input bit hy, output bit lst);
        int pad, nx, ny;
        pad = int'(bus.paddle_x);
        lst = 1'b0;
        case (m_state)
            0: begin
                mx = pad + PADDLE_W / 2 - BS / 2;
                my = PADDLE_Y - BS;
                if (bus.launch) begin
                    m_state = 1; vx = 1; vy = -1;
                end
            end
            1: begin
                if (hx) vx = -vx;
                if (hy) vy = -vy;
                nx = mx + SP * vx;
                ny = my + SP * vy;
                if (vx < 0 && mx < SP) begin
                    nx = 0; vx = 1;
                end else if (vx > 0 && mx + BS + SP > H_RES) begin
                    nx = H_RES - BS; vx = -1;
                end
                if (vy < 0 && my < SP) begin
                    ny = 0; vy = 1;
                end else if (vy > 0 && my + BS <= PADDLE_Y && my + BS + SP >= PADDLE_Y &&
                             mx + BS > pad && mx < pad + PADDLE_W) begin
                    ny = PADDLE_Y - BS; vy = -1;
                end else if (vy > 0 && my + BS + SP >= V_RES) begin
                    m_state = 2; lst = 1'b1; nx = mx; ny = my;
                end
                mx = nx;
                my = ny;
            end
            default: begin
                m_state = 0;
                mx = pad + PADDLE_W / 2 - BS / 2;
                my = PADDLE_Y - BS;
            end
        endcase
    endtask

    task automatic step();
        int exp_o, qx, qy;
        bit exp_lost, hx, hy;
        exp_o = 0;
        exp_lost = 1'b0;
        qx = int'(bus.px);
        qy = int'(bus.py);
        if (reset) begin
            m_state = 0; vx = 1; vy = -1; m_hxp = 1'b0; m_hyp = 1'b0;
            mx = int'(bus.paddle_x) + PADDLE_W / 2 - BS / 2;
            my = PADDLE_Y - BS;
        end else begin
            if (m_state != 2 && qx >= mx && qx < mx + BS && qy >= my && qy < my + BS)
                exp_o = 15;
            hx = m_hxp | bus.block_hit_x;
            hy = m_hyp | bus.block_hit_y;
            if (bus.frame_tick) begin
                model_frame(hx, hy, exp_lost);
                m_hxp = 1'b0; m_hyp = 1'b0;
            end else begin
                m_hxp = hx; m_hyp = hy;
            end
        end
        @(posedge clock);
        #1;
        if (exp_lost) lost_seen++;
        if (bus.lost) dut_lost++;
        chk("o_ball", int'(bus.o_ball), exp_o);
        chk("ball_x", int'(bus.ball_x), mx);
        chk("ball_y", int'(bus.ball_y), my);
        chk("lost", int'(bus.lost), int'(exp_lost));
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        step();
    endtask

    task automatic do_reset(input int pad);
        bus.paddle_x = 10'(pad);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.frame_tick = 1'b0; bus.launch = 1'b0;
        bus.block_hit_x = 1'b0; bus.block_hit_y = 1'b0;
        bus.px = '0; bus.py = '0; bus.paddle_x = 10'd288;
        lost_seen = 0; dut_lost = 0;

        step();
        bus.frame_tick = 1'b1; bus.launch = 1'b1;
        step();
        bus.frame_tick = 1'b0; bus.launch = 1'b0;
        reset = 1'b0;
        chk("rst_x", int'(bus.ball_x), 316);
        chk("rst_y", int'(bus.ball_y), 432);
        chk("rst_o_ball", int'(bus.o_ball), 0);
        chk("rst_lost", int'(bus.lost), 0);

        frame();
        chk("serve_x", int'(bus.ball_x), 316);
        bus.px = 10'd316; bus.py = 10'd432;
        step();
        chk("pix_in", int'(bus.o_ball), 15);
        bus.px = 10'd324;
        step();
        chk("pix_out", int'(bus.o_ball), 0);

        bus.launch = 1'b1;
        frame();
        bus.launch = 1'b0;
        chk("launch_x", int'(bus.ball_x), 316);
        chk("launch_y", int'(bus.ball_y), 432);
        frame();
        chk("move1", int'(bus.ball_x) * 1000 + int'(bus.ball_y), 318430);
        frame();
        chk("move2", int'(bus.ball_x) * 1000 + int'(bus.ball_y), 320428);

        // mid-frame vertical block hit, then one arriving with the tick
        bus.block_hit_y = 1'b1; step(); bus.block_hit_y = 1'b0; step();
        frame();
        chk("bhy_mid", int'(bus.ball_y), 430);
        bus.frame_tick = 1'b1; bus.block_hit_y = 1'b1; step();
        bus.frame_tick = 1'b0; bus.block_hit_y = 1'b0; step();
        chk("bhy_tick", int'(bus.ball_y), 428);

        do_reset(100);
        chk("midrst_x", int'(bus.ball_x), 128);
        chk("midrst_y", int'(bus.ball_y), 432);
        chk("midrst_o", int'(bus.o_ball), 0);

        // right wall: odd serve position lands exactly on 631
        bus.paddle_x = 10'd575;
        bus.launch = 1'b1; frame(); bus.launch = 1'b0;
        for (int k = 0; k < 14; k++) frame();
        chk("pre_wall_x", int'(bus.ball_x), 631);
        frame();
        chk("wall_x", int'(bus.ball_x), 632);
        frame();
        chk("wall_back_x", int'(bus.ball_x), 630);

        do_reset(575);
        bus.launch = 1'b1; frame(); bus.launch = 1'b0;
        for (int k = 0; k < 14; k++) frame();
        bus.frame_tick = 1'b1; bus.block_hit_x = 1'b1; step();
        bus.frame_tick = 1'b0; bus.block_hit_x = 1'b0; step();
        chk("bhx_wall_x", int'(bus.ball_x), 629);
        frame();
        chk("bhx_after_x", int'(bus.ball_x), 627);

        // let the ball fall past a paddle kept out of its way
        do_reset(288);
        bus.launch = 1'b1; frame(); bus.launch = 1'b0;
        dut_lost = 0; lost_seen = 0;
        for (int k = 0; k < 700 && m_state == 1; k++) begin
            bus.paddle_x = (mx < 300) ? 10'd576 : 10'd0;
            frame();
        end
        chk("lost_model", lost_seen, 1);
        chk("lost_pulses", dut_lost, 1);
        bus.px = 10'(mx); bus.py = 10'(my);
        step();
        chk("lost_hidden", int'(bus.o_ball), 0);
        bus.paddle_x = 10'd200;
        frame();
        chk("reserve_x", int'(bus.ball_x), 228);
        chk("reserve_y", int'(bus.ball_y), 432);

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            bus.frame_tick  = ($urandom_range(0, 2) == 0);
            bus.launch      = ($urandom_range(0, 3) == 0);
            bus.block_hit_x = ($urandom_range(0, 29) == 0);
            bus.block_hit_y = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    bus.paddle_x = 10'(clamp(mx - 28 + int'($urandom_range(0, 80)) - 40, 0, 576));
                else
                    bus.paddle_x = 10'($urandom_range(0, 576));
            end
            bus.px = 10'(clamp(mx + int'($urandom_range(0, 15)) - 4, 0, 1023));
            bus.py = 10'(clamp(my + int'($urandom_range(0, 15)) - 4, 0, 1023));
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/draw_ball.md
Name: draw_ball

Overview:
- Upstream renderer for the ball layer. Produces the 4-bit {hit, rgb} code consumed by the priority mixer as its ball input.
- Owns ball position, direction and the serve/play/lost state machine.
- Position advances once per frame on frame_tick. Pixel membership is evaluated every clock against the current scan coordinates.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
BALL_SIZE, 8, ball edge length in pixels (square)
PADDLE_Y, 440, top row of the paddle
PADDLE_W, 64, paddle width in pixels
SPEED, 2, pixels moved per axis per frame
BALL_RGB, 3'b111, ball colour

Ports:
clock  in  1  system/pixel clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse at start of vertical blank
launch  in  1  serve request, level, sampled only on frame_tick
px  in  10  current scan column
py  in  10  current scan row
paddle_x  in  10  paddle left edge; always <= H_RES-PADDLE_W
block_hit_x  in  1  one-cycle pulse: block collision reverses horizontal direction
block_hit_y  in  1  one-cycle pulse: block collision reverses vertical direction
o_ball  out  4  {hit, rgb} code for the pixel at (px,py)
ball_x  out  10  ball left edge
ball_y  out  10  ball top edge
lost  out  1  one-cycle pulse when the ball passes the bottom edge

Behaviour:
- One clock; reset is synchronous and active-high, named reset; clock named clock.
- Reset values:
  - state=SERVE
  - ball_x = paddle_x + PADDLE_W/2 - BALL_SIZE/2
  - ball_y = PADDLE_Y - BALL_SIZE
  - dx=+ (right), dy=- (up)
  - o_ball=4'b0000, lost=0, both pending-hit flags=0
- Pixel path:
  - o_ball is registered with 1-cycle latency from px/py.
  - o_ball = {1, BALL_RGB} when state!=LOST and ball_x <= px < ball_x+BALL_SIZE and ball_y <= py < ball_y+BALL_SIZE.
  - Otherwise o_ball = 4'b0000.
  - Comparisons use 11-bit sums so that ball_x+BALL_SIZE cannot wrap.
- Pending hits:
  - block_hit_x/y set sticky flags px_pend/py_pend on any cycle.
  - Flags are consumed and cleared on the next frame_tick.
  - A pulse arriving in the same cycle as frame_tick counts toward that tick.
- All state and position updates happen only in the frame_tick cycle.
- SERVE:
  - Ball tracks the paddle: ball_x = paddle_x+PADDLE_W/2-BALL_SIZE/2, ball_y = PADDLE_Y-BALL_SIZE.
  - If launch=1 -> MOVING with dx=+, dy=-. Position is not advanced in that tick.
  - Pending flags are cleared and ignored.
- MOVING, evaluated in this order:
  1. Apply pending flags: toggle dx if px_pend, toggle dy if py_pend.
  2. Horizontal walls:
     - dx=- and ball_x < SPEED: ball_x=0, dx=+.
     - dx=+ and ball_x+BALL_SIZE+SPEED > H_RES: ball_x=H_RES-BALL_SIZE, dx=-.
     - Otherwise ball_x ± SPEED.
  3. Vertical:
     - Top: dy=- and ball_y < SPEED: ball_y=0, dy=+.
     - Paddle: dy=+, ball_y+BALL_SIZE <= PADDLE_Y, ball_y+BALL_SIZE+SPEED >= PADDLE_Y, and ball_x+BALL_SIZE > paddle_x and ball_x < paddle_x+PADDLE_W. Then ball_y=PADDLE_Y-BALL_SIZE, dy=-.
     - Floor: dy=+ and ball_y+BALL_SIZE+SPEED >= V_RES. Then state=LOST and lost=1 for exactly this cycle; position is held.
     - Otherwise ball_y ± SPEED.
  - Wall and paddle results override a block toggle on the same axis in the same tick, because direction is assigned explicitly.
  - The paddle test takes priority over the floor test.
- LOST:
  - Ball is not drawn.
  - Next frame_tick -> SERVE, with position snapped to the paddle in that same tick.
- frame_tick during reset is ignored.
- Reset mid-frame returns to SERVE immediately; o_ball reads 0 in the cycle after reset.

Decomposition:
- Shared package game_pkg:
  - H_RES, V_RES, PADDLE_Y, PADDLE_W, colour constants.
  - 2-bit state enum: SERVE=0, MOVING=1, LOST=2.
  - The 4-bit layer-code layout {hit, r, g, b}.
- Sub-module rect_hit: combinational 11-bit rectangle-contains-point check with inputs x, y, w, h, px, py. Reused by the paddle and block renderers.

Test Plan:
- Reset with paddle_x=288, then frame_tick -> ball_x=316, ball_y=432, state SERVE. With px=316, py=432: o_ball=4'b1111 one cycle later. With px=324: o_ball=0.
- launch=1 on tick 1 -> MOVING at (316,432). Tick 2 -> (318,430). Tick 3 -> (320,428).
- MOVING, dx=+, ball_x=631 on tick -> ball_x=632, dx=-. Next tick -> 630. Also ball_y=1, dy=- -> ball_y=0, dy=+.
- dy=+, ball_y=431, paddle_x=300, ball_x=320 on tick -> ball_y=432, dy=-. Same position with paddle_x=0 -> continues to ball_y=433; later crossing 472 -> lost pulses 1 cycle, o_ball=0 everywhere, next tick -> SERVE.
- block_hit_y pulse mid-frame with dy=- at ball_y=200 -> next tick ball_y=202, dy=+. block_hit_x coinciding with a right-wall bounce -> dx=- (wall wins).
- Assert reset while MOVING at (100,100) -> next cycle SERVE on the paddle, o_ball=0, lost=0.
